// File: rtl/keccak_perm_ctrl.sv
// Round/block sequencer for the Keccak-f permutation datapath with abort and sticky status/interrupt.
// Optional busy-cycle counter port perf_cycles_o is enabled by defining KECCAK_PERM_CTRL_PERF_EN.
module keccak_perm_ctrl #(
  parameter int NUM_ROUNDS = 24,
  parameter int CNT_W      = $clog2(NUM_ROUNDS),
  parameter int BLK_W      = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [BLK_W-1:0] nblocks_i,
  input  logic             ready_dp_i,
  input  logic             blk_valid_i,
  input  logic             abort_i,
  input  logic             intr_en_i,
  input  logic             intr_clr_i,
  output logic             start_dp_o,
  output logic             round_en_o,
  output logic [CNT_W-1:0] round_idx_o,
  output logic             last_round_o,
  output logic             blk_req_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             status_d_o,
  output logic             keccak_intr_o
`ifdef KECCAK_PERM_CTRL_PERF_EN
  ,
  output logic [31:0]      perf_cycles_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROUND,
    S_BLK_WAIT,
    S_FINISH
  } state_e;

  localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(NUM_ROUNDS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rnd_q, rnd_d;
  logic [BLK_W-1:0] blk_cnt_q, blk_cnt_d;
  logic [BLK_W-1:0] nblk_q, nblk_d;
  logic             status_q, status_d;
  logic             intr_q, intr_d;
  logic             job_start;
  logic             job_end;
  logic             abort_act;

  assign abort_act = abort_i && (state_q != S_IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rnd_q     <= '0;
      blk_cnt_q <= '0;
      nblk_q    <= '0;
      status_q  <= 1'b0;
      intr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rnd_q     <= rnd_d;
      blk_cnt_q <= blk_cnt_d;
      nblk_q    <= nblk_d;
      status_q  <= status_d;
      intr_q    <= intr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    rnd_d        = rnd_q;
    blk_cnt_d    = blk_cnt_q;
    nblk_d       = nblk_q;
    start_dp_o   = 1'b0;
    round_en_o   = 1'b0;
    last_round_o = 1'b0;
    blk_req_o    = 1'b0;
    done_o       = 1'b0;
    job_start    = 1'b0;
    job_end      = 1'b0;

    case (state_q)
      S_IDLE: begin
        rnd_d     = '0;
        blk_cnt_d = '0;
        if (start_i && ready_dp_i) begin
          start_dp_o = 1'b1;
          job_start  = 1'b1;
          nblk_d     = (nblocks_i == '0) ? BLK_W'(1) : nblocks_i;
          state_d    = S_ROUND;
        end
      end
      S_ROUND: begin
        round_en_o = 1'b1;
        if (rnd_q == RND_LAST) begin
          last_round_o = 1'b1;
          rnd_d        = '0;
          if (blk_cnt_q + BLK_W'(1) == nblk_q) begin
            state_d = S_FINISH;
          end else begin
            blk_cnt_d = blk_cnt_q + BLK_W'(1);
            state_d   = S_BLK_WAIT;
          end
        end else begin
          rnd_d = rnd_q + CNT_W'(1);
        end
      end
      S_BLK_WAIT: begin
        blk_req_o = 1'b1;
        rnd_d     = '0;
        if (blk_valid_i && ready_dp_i) begin
          start_dp_o = 1'b1;
          state_d    = S_ROUND;
        end
      end
      S_FINISH: begin
        done_o    = 1'b1;
        job_end   = 1'b1;
        blk_cnt_d = '0;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides every transition and suppresses any start or completion side effect
    if (abort_act) begin
      state_d    = S_IDLE;
      rnd_d      = '0;
      blk_cnt_d  = '0;
      start_dp_o = 1'b0;
      done_o     = 1'b0;
      job_end    = 1'b0;
    end
  end

  // Completion set is applied after the clear so a coincident clear loses
  always_comb begin
    status_d = status_q;
    intr_d   = intr_q;
    if (intr_clr_i) begin
      status_d = 1'b0;
      intr_d   = 1'b0;
    end
    if (job_start) begin
      status_d = 1'b0;
    end
    if (job_end) begin
      status_d = 1'b1;
      if (intr_en_i) begin
        intr_d = 1'b1;
      end
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign round_idx_o   = rnd_q;
  assign status_d_o    = status_q;
  assign keccak_intr_o = intr_q;

`ifdef KECCAK_PERM_CTRL_PERF_EN
  logic [31:0] perf_q, perf_d;

  // The accepting cycle counts as the first cycle of the job
  always_comb begin
    perf_d = perf_q;
    if (job_start) begin
      perf_d = 32'd1;
    end else if (busy_o && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_cycles_o = perf_q;
`endif

endmodule

// File: tb/tb_keccak_perm_ctrl.sv
// Scoreboard bench for keccak_perm_ctrl: job tasks queue expected per-job counts, a monitor checks them on done_o.
module tb_keccak_perm_ctrl;
  localparam int NR = 24;
  localparam int CW = 5;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst_i, start_i, ready_dp_i, blk_valid_i, abort_i, intr_en_i, intr_clr_i;
  logic [BW-1:0] nblocks_i;
  logic          start_dp_o, round_en_o, last_round_o, blk_req_o, busy_o, done_o;
  logic          status_d_o, keccak_intr_o;
  logic [CW-1:0] round_idx_o;
`ifdef KECCAK_PERM_CTRL_PERF_EN
  logic [31:0]   perf_cycles_o;
`endif

  keccak_perm_ctrl #(.NUM_ROUNDS(NR), .CNT_W(CW), .BLK_W(BW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .nblocks_i(nblocks_i),
    .ready_dp_i(ready_dp_i), .blk_valid_i(blk_valid_i), .abort_i(abort_i),
    .intr_en_i(intr_en_i), .intr_clr_i(intr_clr_i), .start_dp_o(start_dp_o),
    .round_en_o(round_en_o), .round_idx_o(round_idx_o), .last_round_o(last_round_o),
    .blk_req_o(blk_req_o), .busy_o(busy_o), .done_o(done_o),
    .status_d_o(status_d_o), .keccak_intr_o(keccak_intr_o)
`ifdef KECCAK_PERM_CTRL_PERF_EN
    , .perf_cycles_o(perf_cycles_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int st;
    int rd;
    int lr;
    int rq;
  } job_t;

  job_t sb_q[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   m_st, m_rd, m_lr, m_rq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [12:0] outvec();
    return {start_dp_o, round_en_o, round_idx_o, last_round_o, blk_req_o,
            busy_o, done_o, status_d_o, keccak_intr_o};
  endfunction

  // Monitor: accumulate per-job activity, compare against the queued job on done_o
  always @(negedge clk) begin
    job_t e;
    if (rst_i) begin
      m_st = 0; m_rd = 0; m_lr = 0; m_rq = 0;
    end else begin
      if (start_dp_o && !busy_o) begin
        m_st = 0; m_rd = 0; m_lr = 0; m_rq = 0;
      end
      if (start_dp_o)   m_st++;
      if (round_en_o)   m_rd++;
      if (last_round_o) m_lr++;
      if (blk_req_o)    m_rq++;
      if (done_o) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_start_pulses", m_st, e.st);
          chk("sb_round_cycles", m_rd, e.rd);
          chk("sb_last_rounds", m_lr, e.lr);
          chk("sb_blk_req_cycles", m_rq, e.rq);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    intr_clr_i = 1'b1;
    step();
    intr_clr_i = 1'b0;
    chk("clr_status", status_d_o, 0);
    chk("clr_intr", keccak_intr_o, 0);
  endtask

  task automatic run_job(input int nb, input int dly, input bit en, input bit clr_fin, input int hold);
    int nbe, w, guard;
    nbe = (nb == 0) ? 1 : nb;
    sb_q.push_back('{nbe, nbe * NR, nbe, (nbe - 1) * dly});
    step();
    start_i    = 1'b1;
    nblocks_i  = BW'(nb);
    intr_en_i  = en;
    ready_dp_i = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      #1;
      chk("held_off", {busy_o, start_dp_o}, 0);
      step();
    end
    ready_dp_i = 1'b1;
    #1;
    chk("start_dp", start_dp_o, 1);
    step();
    start_i = 1'b0;
    w = 0;
    guard = 0;
    while (!done_o && guard < 2000) begin
      if (blk_req_o) begin
        w++;
        blk_valid_i = (w == dly);
      end else begin
        w = 0;
        blk_valid_i = 1'b0;
      end
      step();
      guard++;
    end
    chk("done_seen", guard < 2000, 1);
    blk_valid_i = 1'b0;
    intr_clr_i  = clr_fin;
    step();
    intr_clr_i = 1'b0;
    chk("job_busy_end", busy_o, 0);
    chk("job_status", status_d_o, 1);
    chk("job_intr", keccak_intr_o, en);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w, guard;
    bit seen;
    rst_i = 1'b1; start_i = 1'b0; ready_dp_i = 1'b0; blk_valid_i = 1'b0;
    abort_i = 1'b0; intr_en_i = 1'b0; intr_clr_i = 1'b0; nblocks_i = '0;
    repeat (3) step();
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("reset_idle_outputs", outvec(), 0);
      step();
    end
    ready_dp_i = 1'b1;

    // Single-block latency walk
    sb_q.push_back('{1, NR, 1, 0});
    start_i = 1'b1; nblocks_i = BW'(1); intr_en_i = 1'b1;
    #1;
    chk("lat_start_dp", start_dp_o, 1);
    step();
    start_i = 1'b0;
    for (int i = 0; i < NR; i++) begin
      logic [6:0] e;
      e = {1'b1, (i == NR - 1), 5'(i)};
      chk("lat_round", {round_en_o, last_round_o, round_idx_o}, e);
      step();
    end
    chk("lat_done", {done_o, busy_o, status_d_o}, 3'b110);
    step();
    chk("lat_status_intr", {busy_o, done_o, status_d_o, keccak_intr_o}, 4'b0011);
`ifdef KECCAK_PERM_CTRL_PERF_EN
    chk("perf_cycles", perf_cycles_o, 26);
`endif
    clr_pulse();

    run_job(3, 5, 1'b1, 1'b0, 0);
    clr_pulse();

    // Abort during round 10 of block 2
    step();
    start_i = 1'b1; nblocks_i = BW'(3); intr_en_i = 1'b1;
    step();
    start_i = 1'b0;
    w = 0; guard = 0; seen = 1'b0;
    while (!(seen && round_en_o && round_idx_o == CW'(10)) && guard < 500) begin
      if (blk_req_o) begin
        seen = 1'b1;
        w++;
        blk_valid_i = (w == 2);
      end else begin
        w = 0;
        blk_valid_i = 1'b0;
      end
      step();
      guard++;
    end
    chk("abort_reached", guard < 500, 1);
    blk_valid_i = 1'b0;
    chk("pre_abort_status", status_d_o, 0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    chk("abort_idle", outvec(), 0);
    repeat (30) step();
    chk("abort_stays_idle", {busy_o, status_d_o, keccak_intr_o}, 0);

    run_job(1, 1, 1'b1, 1'b0, 0);
    clr_pulse();
    run_job(1, 1, 1'b1, 1'b1, 0);
    clr_pulse();
    run_job(1, 1, 1'b0, 1'b0, 0);
    run_job(0, 1, 1'b1, 1'b0, 4);

    // Reset in the middle of a job clears the sticky bits too
    step();
    start_i = 1'b1; nblocks_i = BW'(2);
    step();
    start_i = 1'b0;
    repeat (5) step();
    chk("midjob_busy", busy_o, 1);
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    chk("midjob_reset", outvec(), 0);

    repeat (5) step();
    chk("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
